// File: rtl/lia_excitation_generator.sv
// lia_excitation_generator: phase-continuous DDS sine source with gain, phase offset and exported reference phase.
// Define EXC_SWEEP_EN to compile in the stepped frequency-sweep FSM; otherwise current_tw follows tuning_word.
module lia_excitation_generator #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 32,
  parameter int LUT_AW      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   sample_tick,
  input  logic [PHASE_WIDTH-1:0] tuning_word,
  input  logic [15:0]            amplitude,
  input  logic [15:0]            phase_offset,
  input  logic                   sweep_start,
  input  logic [PHASE_WIDTH-1:0] sweep_start_tw,
  input  logic [PHASE_WIDTH-1:0] sweep_step_tw,
  input  logic [15:0]            sweep_steps,
  input  logic [15:0]            dwell_samples,
  output logic [DATA_WIDTH-1:0]  exc_data,
  output logic                   exc_valid,
  output logic                   cycle_sync,
  output logic [PHASE_WIDTH-1:0] ref_phase,
  output logic [PHASE_WIDTH-1:0] current_tw,
  output logic                   sweep_busy,
  output logic                   sweep_done,
  output logic [15:0]            sweep_idx
);
  localparam int MW = DATA_WIDTH - 1;
  localparam int QW = LUT_AW + 2;
  localparam longint FS = (longint'(1) <<< MW) - 1;
  // Quarter-wave table from a 2^30 fixed-point Taylor series, folded to constants at elaboration
  function automatic logic [MW-1:0] lut_val(input int k);
    longint x, x2, term, sum;
    x = (64'sd3373259426 * longint'(2 * k + 1)) >>> QW;
    x2 = (x * x) >>> 30;
    term = x;
    sum = x;
    for (int n = 1; n < 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum = sum + term;
    end
    return MW'((sum * FS + (longint'(1) <<< 29)) >>> 30);
  endfunction
  logic [MW-1:0] lut [2**LUT_AW];
  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_lut
    assign lut[k] = lut_val(k);
  end
  logic [PHASE_WIDTH-1:0] phase, r1, r2;
  logic [QW-1:0] p1;
  logic [DATA_WIDTH-1:0] sine2;
  logic [MW-1:0] mag;
  logic v1, v2, c1, c2;
  always_comb begin
    mag = lut[p1[QW-2] ? ~p1[QW-3:0] : p1[QW-3:0]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      p1 <= '0;
      r1 <= '0;
      r2 <= '0;
      c1 <= 1'b0;
      c2 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      sine2 <= '0;
      exc_data <= '0;
      exc_valid <= 1'b0;
      cycle_sync <= 1'b0;
      ref_phase <= '0;
    end else begin
      v1 <= enable && sample_tick;
      v2 <= enable && v1;
      exc_valid <= enable && v2;
      cycle_sync <= enable && v2 && c2;
      if (!enable) phase <= '0;
      else if (sample_tick) begin
        {c1, phase} <= {1'b0, phase} + {1'b0, current_tw};
        p1 <= QW'((phase[PHASE_WIDTH-1 -: 16] + phase_offset) >> (16 - QW));
        r1 <= phase;
      end
      if (v1) begin
        sine2 <= p1[QW-1] ? -{1'b0, mag} : {1'b0, mag};
        r2 <= r1;
        c2 <= c1;
      end
      // 33-bit signed product; taking bits above 16 floors like an arithmetic shift
      if (enable && v2) begin
        exc_data <= DATA_WIDTH'(({{17{sine2[DATA_WIDTH-1]}}, sine2} * {{(DATA_WIDTH + 1){1'b0}}, amplitude}) >> 16);
        ref_phase <= r2;
      end
    end
  end
`ifdef EXC_SWEEP_EN
  typedef enum logic {IDLE, DWELL} state_t;
  state_t state, state_nx;
  logic [15:0] dwell_cnt, dwell_last;
  logic start_ok, tick_dw, step_evt, last_step;
  always_comb begin
    dwell_last = dwell_samples == 16'd0 ? 16'd0 : dwell_samples - 16'd1;
    start_ok = enable && sweep_start && state == IDLE;
    tick_dw = enable && sample_tick && state == DWELL;
    step_evt = tick_dw && dwell_cnt >= dwell_last;
    last_step = sweep_idx == sweep_steps - 16'd1;
    state_nx = !enable ? IDLE : (start_ok && sweep_steps != 16'd0) ? DWELL : (step_evt && last_step) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dwell_cnt <= '0;
      sweep_idx <= '0;
      sweep_done <= 1'b0;
      current_tw <= '0;
    end else begin
      state <= state_nx;
      sweep_done <= (start_ok && sweep_steps == 16'd0) || (step_evt && last_step);
      dwell_cnt <= start_ok ? '0 : tick_dw ? (step_evt ? '0 : dwell_cnt + 16'd1) : dwell_cnt;
      sweep_idx <= start_ok ? '0 : (step_evt && !last_step) ? sweep_idx + 16'd1 : sweep_idx;
      current_tw <= state_nx == IDLE ? tuning_word : start_ok ? sweep_start_tw : step_evt ? current_tw + sweep_step_tw : current_tw;
    end
  end
  assign sweep_busy = state == DWELL;
`else
  logic unused_sweep;
  assign unused_sweep = ^{sweep_start, sweep_start_tw, sweep_step_tw, sweep_steps, dwell_samples};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) current_tw <= '0;
    else current_tw <= tuning_word;
  end
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;
  assign sweep_idx = '0;
`endif
endmodule

// File: tb/tb_lia_excitation_generator.sv
// tb_lia_excitation_generator: directed vector bench for the DDS excitation generator.
// Sweep sequences run when EXC_SWEEP_EN is defined; otherwise the tied-off sweep outputs are checked.
module tb_lia_excitation_generator;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, sample_tick = 1'b0, sweep_start = 1'b0;
  logic [31:0] tuning_word = '0, sweep_start_tw = '0, sweep_step_tw = '0;
  logic [15:0] amplitude = '0, phase_offset = '0, sweep_steps = '0, dwell_samples = '0;
  logic [15:0] exc_data, sweep_idx;
  logic exc_valid, cycle_sync, sweep_busy, sweep_done;
  logic [31:0] ref_phase, current_tw;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  lia_excitation_generator dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_tick(sample_tick),
    .tuning_word(tuning_word), .amplitude(amplitude), .phase_offset(phase_offset),
    .sweep_start(sweep_start), .sweep_start_tw(sweep_start_tw), .sweep_step_tw(sweep_step_tw),
    .sweep_steps(sweep_steps), .dwell_samples(dwell_samples),
    .exc_data(exc_data), .exc_valid(exc_valid), .cycle_sync(cycle_sync), .ref_phase(ref_phase),
    .current_tw(current_tw), .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_idx(sweep_idx)
  );

  typedef struct {
    logic [31:0] tw;
    logic [15:0] amp;
    logic [15:0] off;
    int          d [4];
    logic [3:0]  sync;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input logic signed [15:0] act, input int exp);
    n_cmp++;
    if (int'(act) > exp + 1 || int'(act) < exp - 1) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (+/-1)", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " exc_data"}, exc_data, 0);
    chk({tag, " exc_valid"}, exc_valid, 0);
    chk({tag, " cycle_sync"}, cycle_sync, 0);
    chk({tag, " ref_phase"}, ref_phase, 0);
    chk({tag, " current_tw"}, current_tw, 0);
    chk({tag, " sweep_busy"}, sweep_busy, 0);
    chk({tag, " sweep_done"}, sweep_done, 0);
    chk({tag, " sweep_idx"}, sweep_idx, 0);
  endtask

  initial begin
    vecs[0] = '{32'h4000_0000, 16'hFFFF, 16'h0000, '{100, 32766, -101, -32767}, 4'b1000};
    vecs[1] = '{32'h4000_0000, 16'hFFFF, 16'h4000, '{32766, -101, -32767, 100}, 4'b1000};
    vecs[2] = '{32'h4000_0000, 16'h8000, 16'h4000, '{16383, -51, -16384, 50}, 4'b1000};
    vecs[3] = '{32'h8000_0000, 16'hFFFF, 16'h0000, '{100, -101, 100, -101}, 4'b1010};
    vecs[4] = '{32'h0000_0000, 16'hFFFF, 16'h2000, '{23240, 23240, 23240, 23240}, 4'b0000};
    vecs[5] = '{32'h4000_0000, 16'h0000, 16'h0000, '{0, 0, 0, 0}, 4'b1000};
    vecs[6] = '{32'h4000_0000, 16'hFFFF, 16'hC000, '{-32767, 100, 32766, -101}, 4'b1000};
    #2;
    chk_rst("reset");
    #20 rst_n = 1'b1;
    step();
    // each vector: one disabled cycle to clear phase and load the word, then 4 back-to-back ticks
    for (int v = 0; v < 7; v++) begin
      enable = 1'b0;
      tuning_word = vecs[v].tw;
      amplitude = vecs[v].amp;
      phase_offset = vecs[v].off;
      step();
      enable = 1'b1;
      sample_tick = 1'b1;
      for (int c = 0; c < 6; c++) begin
        step();
        if (c == 3) sample_tick = 1'b0;
        if (c == 1) chk($sformatf("v%0d latency", v), exc_valid, 0);
        if (c >= 2) begin
          logic [31:0] r;
          r = vecs[v].tw * 32'(c - 2);
          chk($sformatf("v%0d s%0d valid", v, c - 2), exc_valid, 1);
          chk_near($sformatf("v%0d s%0d data", v, c - 2), exc_data, vecs[v].d[c - 2]);
          chk($sformatf("v%0d s%0d sync", v, c - 2), cycle_sync, 32'(vecs[v].sync[c - 2]));
          chk($sformatf("v%0d s%0d ref", v, c - 2), ref_phase, r);
        end
      end
      step();
      chk($sformatf("v%0d valid drop", v), exc_valid, 0);
    end

    // enable low flushes samples already in flight
    tuning_word = 32'h4000_0000;
    amplitude = 16'hFFFF;
    phase_offset = 16'h0;
    step();
    sample_tick = 1'b1;
    step(2);
    sample_tick = 1'b0;
    enable = 1'b0;
    step();
    chk("flush valid a", exc_valid, 0);
    step();
    chk("flush valid b", exc_valid, 0);
    chk("flush sync", cycle_sync, 0);

    // asynchronous reset in the middle of a tick stream
    enable = 1'b1;
    step();
    sample_tick = 1'b1;
    step(6);
    chk("pre-reset valid", exc_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_rst("mid reset");
    sample_tick = 1'b0;
    tuning_word = 32'h1234;
    #1 rst_n = 1'b1;
    #1 chk("tw before first clock", current_tw, 0);
    step();
    chk("tw after release", current_tw, 32'h1234);
    tuning_word = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post-reset data %0d", i), exc_data, 0);
      chk($sformatf("post-reset valid %0d", i), exc_valid, 0);
    end

`ifdef EXC_SWEEP_EN
    tuning_word = 32'h777;
    sweep_start_tw = 32'd1000;
    sweep_step_tw = 32'd500;
    sweep_steps = 16'd3;
    dwell_samples = 16'd4;
    step();
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    chk("sweep busy", sweep_busy, 1);
    chk("sweep done early", sweep_done, 0);
    // a second start at tick 5 must be ignored
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("sweep tw %0d", i), current_tw, 32'(1000 + 500 * (i / 4)));
      chk($sformatf("sweep idx %0d", i), sweep_idx, 32'(i / 4));
      chk($sformatf("sweep busy %0d", i), sweep_busy, 1);
      sample_tick = 1'b1;
      sweep_start = (i == 5);
      step();
    end
    sample_tick = 1'b0;
    sweep_start = 1'b0;
    chk("sweep done", sweep_done, 1);
    chk("sweep busy end", sweep_busy, 0);
    chk("sweep tw revert", current_tw, 32'h777);
    step();
    chk("sweep done pulse", sweep_done, 0);

    sweep_steps = 16'd0;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    chk("zero-step done", sweep_done, 1);
    chk("zero-step busy", sweep_busy, 0);
    step();
    chk("zero-step done pulse", sweep_done, 0);
    chk("zero-step busy after", sweep_busy, 0);

    sweep_steps = 16'd2;
    dwell_samples = 16'd0;
    sweep_start_tw = 32'hFFFF_FFF0;
    sweep_step_tw = 32'h20;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    chk("wrap first tw", current_tw, 32'hFFFF_FFF0);
    sample_tick = 1'b1;
    step();
    chk("wrap second tw", current_tw, 32'h10);
    chk("wrap idx", sweep_idx, 1);
    chk("wrap done early", sweep_done, 0);
    step();
    sample_tick = 1'b0;
    chk("wrap done", sweep_done, 1);
    chk("wrap tw revert", current_tw, 32'h777);

    enable = 1'b0;
    sweep_steps = 16'd3;
    dwell_samples = 16'd4;
    sweep_start_tw = 32'd1000;
    sweep_step_tw = 32'd500;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    chk("disabled start busy", sweep_busy, 0);
    chk("disabled start done", sweep_done, 0);
    enable = 1'b1;

    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    sample_tick = 1'b1;
    step(5);
    sample_tick = 1'b0;
    chk("abort idx", sweep_idx, 1);
    chk("abort tw", current_tw, 32'd1500);
    enable = 1'b0;
    step();
    chk("abort busy", sweep_busy, 0);
    chk("abort done", sweep_done, 0);
    chk("abort tw revert", current_tw, 32'h777);
    step();
    chk("abort done later", sweep_done, 0);
`else
    tuning_word = 32'h55;
    sweep_start_tw = 32'd1000;
    sweep_step_tw = 32'd500;
    sweep_steps = 16'd3;
    dwell_samples = 16'd1;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    sample_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("nosweep tw %0d", i), current_tw, 32'h55);
      chk($sformatf("nosweep busy %0d", i), sweep_busy, 0);
      chk($sformatf("nosweep done %0d", i), sweep_done, 0);
      chk($sformatf("nosweep idx %0d", i), sweep_idx, 0);
    end
    sample_tick = 1'b0;
    enable = 1'b0;
    step();
`endif

    // phase restarts from 0 after re-enable
    tuning_word = 32'h4000_0000;
    amplitude = 16'hFFFF;
    phase_offset = 16'h0;
    step();
    enable = 1'b1;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step(2);
    chk("restart valid", exc_valid, 1);
    chk("restart ref", ref_phase, 0);
    chk_near("restart data", exc_data, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
